control_sequencer: RTL and testbench

//  Fetch/execute stepper and microcode decoder driving the shared CPU bus control lines.

---
 rtl/xdn_control_pkg.sv | 50 +++++
 rtl/control_sequencer_microcode_rom.sv | 101 ++++++++++
 rtl/control_sequencer.sv | 96 +++++++++
 tb/tb_control_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/xdn_control_pkg.sv
// Shared constants for the control sequencer: opcodes, step numbers and
// control-word bit positions. Control-word bits are active-high internally;
// the top level converts them to the bus polarity.
package xdn_control_pkg;

   localparam int OPCODE_W = 4;
   localparam int STEP_W   = 3;
   localparam int CW_W     = 16;

   // Opcodes (IR[7:4])
   localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
   localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
   localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
   localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

   // Step numbers
   localparam logic [STEP_W-1:0] T0 = 3'd0;
   localparam logic [STEP_W-1:0] T1 = 3'd1;
   localparam logic [STEP_W-1:0] T2 = 3'd2;
   localparam logic [STEP_W-1:0] T3 = 3'd3;
   localparam logic [STEP_W-1:0] T4 = 3'd4;

   // Control-word bit indices
   localparam int CW_PC_COUNT  = 0;
   localparam int CW_PC_JUMP   = 1;
   localparam int CW_PC_OUT    = 2;
   localparam int CW_MAR_LOAD  = 3;
   localparam int CW_RAM_OUT   = 4;
   localparam int CW_RAM_WRITE = 5;
   localparam int CW_IR_LOAD   = 6;
   localparam int CW_IR_OUT    = 7;
   localparam int CW_A_LOAD    = 8;
   localparam int CW_A_OUT     = 9;
   localparam int CW_B_LOAD    = 10;
   localparam int CW_ALU_OUT   = 11;
   localparam int CW_ALU_SUB   = 12;
   localparam int CW_FLAGS_LD  = 13;
   localparam int CW_OUT_LOAD  = 14;
   localparam int CW_HALT      = 15;  // internal: sets the halt register

   localparam logic [CW_W-1:0] CW_IDLE = '0;

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Microcode ROM: purely combinational {opcode, step, C, Z} -> {control word, last}.
// Steps 5-7 are unreachable in normal operation; they decode to an idle word
// flagged as last so the sequencer falls straight back to T0.
module microcode_rom
   import xdn_control_pkg::*;
#(
   parameter int OPCODE_WIDTH = OPCODE_W,
   parameter int STEP_WIDTH   = STEP_W
) (
   input  logic [OPCODE_WIDTH-1:0] i_opcode,
   input  logic [STEP_WIDTH-1:0]   i_step,
   input  logic                    i_carry,
   input  logic                    i_zero,
   output logic [CW_W-1:0]         o_cw,
   output logic                    o_last
);

   // Decode fetch steps commonly, execute steps per opcode
   always_comb begin
      o_cw   = CW_IDLE;
      o_last = 1'b0;
      case (i_step)
         T0: begin
            o_cw[CW_PC_OUT]   = 1'b1;
            o_cw[CW_MAR_LOAD] = 1'b1;
         end
         T1: begin
            o_cw[CW_RAM_OUT]  = 1'b1;
            o_cw[CW_IR_LOAD]  = 1'b1;
            o_cw[CW_PC_COUNT] = 1'b1;
         end
         T2: begin
            case (i_opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  o_cw[CW_IR_OUT]   = 1'b1;
                  o_cw[CW_MAR_LOAD] = 1'b1;
               end
               OP_LDI: begin
                  o_cw[CW_IR_OUT] = 1'b1;
                  o_cw[CW_A_LOAD] = 1'b1;
                  o_last          = 1'b1;
               end
               OP_JMP: begin
                  o_cw[CW_IR_OUT]  = 1'b1;
                  o_cw[CW_PC_JUMP] = 1'b1;
                  o_last           = 1'b1;
               end
               OP_JC: begin
                  o_cw[CW_IR_OUT]  = i_carry;
                  o_cw[CW_PC_JUMP] = i_carry;
                  o_last           = 1'b1;
               end
               OP_JZ: begin
                  o_cw[CW_IR_OUT]  = i_zero;
                  o_cw[CW_PC_JUMP] = i_zero;
                  o_last           = 1'b1;
               end
               OP_OUT: begin
                  o_cw[CW_A_OUT]    = 1'b1;
                  o_cw[CW_OUT_LOAD] = 1'b1;
                  o_last            = 1'b1;
               end
               // HLT is not "last": the halt bit freezes the step at T2
               OP_HLT: o_cw[CW_HALT] = 1'b1;
               // NOP and undefined opcodes
               default: o_last = 1'b1;
            endcase
         end
         T3: begin
            case (i_opcode)
               OP_LDA: begin
                  o_cw[CW_RAM_OUT] = 1'b1;
                  o_cw[CW_A_LOAD]  = 1'b1;
                  o_last           = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  o_cw[CW_RAM_OUT] = 1'b1;
                  o_cw[CW_B_LOAD]  = 1'b1;
               end
               OP_STA: begin
                  o_cw[CW_A_OUT]     = 1'b1;
                  o_cw[CW_RAM_WRITE] = 1'b1;
                  o_last             = 1'b1;
               end
               default: o_last = 1'b1;
            endcase
         end
         T4: begin
            o_last = 1'b1;
            if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
               o_cw[CW_ALU_OUT]  = 1'b1;
               o_cw[CW_A_LOAD]   = 1'b1;
               o_cw[CW_FLAGS_LD] = 1'b1;
               o_cw[CW_ALU_SUB]  = (i_opcode == OP_SUB);
            end
         end
         default: o_last = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute stepper driving the shared CPU bus control lines.
// Holds only the step and halt registers; decoding lives in microcode_rom.
module control_sequencer
   import xdn_control_pkg::*;
#(
   parameter int OPCODE_WIDTH = OPCODE_W,
   parameter int STEP_WIDTH   = STEP_W
) (
   input  logic                    i_CLOCK,
   input  logic                    i_CLEAR_n,
   input  logic                    i_RUN,
   input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
   input  logic                    i_FLAG_CARRY,
   input  logic                    i_FLAG_ZERO,
   output logic                    o_PC_COUNT_ENABLE,
   output logic                    o_PC_JUMP_n,
   output logic                    o_PC_OUTPUT_n,
   output logic                    o_MAR_LOAD_n,
   output logic                    o_RAM_OUTPUT_n,
   output logic                    o_RAM_WRITE_n,
   output logic                    o_IR_LOAD_n,
   output logic                    o_IR_OUTPUT_n,
   output logic                    o_A_LOAD_n,
   output logic                    o_A_OUTPUT_n,
   output logic                    o_B_LOAD_n,
   output logic                    o_ALU_OUTPUT_n,
   output logic                    o_ALU_SUBTRACT,
   output logic                    o_FLAGS_LOAD_n,
   output logic                    o_OUT_LOAD_n,
   output logic                    o_HALTED,
   output logic [STEP_WIDTH-1:0]   o_STEP
);

   logic [STEP_WIDTH-1:0] r_step;
   logic                  r_halted;
   logic [CW_W-1:0]       w_rom_cw;
   logic                  w_rom_last;
   logic                  w_enable;
   logic [CW_W-1:0]       w_cw;

   microcode_rom #(
      .OPCODE_WIDTH (OPCODE_WIDTH),
      .STEP_WIDTH   (STEP_WIDTH)
   ) u_rom (
      .i_opcode (i_OPCODE),
      .i_step   (r_step),
      .i_carry  (i_FLAG_CARRY),
      .i_zero   (i_FLAG_ZERO),
      .o_cw     (w_rom_cw),
      .o_last   (w_rom_last)
   );

   // Reset is in the gate so controls drop the instant i_CLEAR_n falls,
   // not only once the step register has been cleared.
   assign w_enable = i_RUN & ~r_halted & i_CLEAR_n;
   assign w_cw     = w_enable ? w_rom_cw : CW_IDLE;

   // Step counter: hold when stalled or halting, wrap after the last step
   always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
      if (!i_CLEAR_n)
         r_step <= T0;
      else if (!w_enable || w_cw[CW_HALT])
         r_step <= r_step;
      else if (w_rom_last)
         r_step <= T0;
      else
         r_step <= r_step + 1'b1;
   end

   // Halt flag: set at the end of HLT's T2, cleared only by reset
   always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
      if (!i_CLEAR_n)
         r_halted <= 1'b0;
      else if (w_cw[CW_HALT])
         r_halted <= 1'b1;
   end

   assign o_PC_COUNT_ENABLE = w_cw[CW_PC_COUNT];
   assign o_PC_JUMP_n       = ~w_cw[CW_PC_JUMP];
   assign o_PC_OUTPUT_n     = ~w_cw[CW_PC_OUT];
   assign o_MAR_LOAD_n      = ~w_cw[CW_MAR_LOAD];
   assign o_RAM_OUTPUT_n    = ~w_cw[CW_RAM_OUT];
   assign o_RAM_WRITE_n     = ~w_cw[CW_RAM_WRITE];
   assign o_IR_LOAD_n       = ~w_cw[CW_IR_LOAD];
   assign o_IR_OUTPUT_n     = ~w_cw[CW_IR_OUT];
   assign o_A_LOAD_n        = ~w_cw[CW_A_LOAD];
   assign o_A_OUTPUT_n      = ~w_cw[CW_A_OUT];
   assign o_B_LOAD_n        = ~w_cw[CW_B_LOAD];
   assign o_ALU_OUTPUT_n    = ~w_cw[CW_ALU_OUT];
   assign o_ALU_SUBTRACT    = w_cw[CW_ALU_SUB];
   assign o_FLAGS_LOAD_n    = ~w_cw[CW_FLAGS_LD];
   assign o_OUT_LOAD_n      = ~w_cw[CW_OUT_LOAD];
   assign o_HALTED          = r_halted;
   assign o_STEP            = r_step;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-cycle vector table plus
// hand-written reset, stall and halt sequences.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       clr_n;
   logic       run;
   logic [3:0] op;
   logic       fc;
   logic       fz;

   logic       pc_cnt, pc_jmp_n, pc_out_n, mar_n, ram_out_n, ram_wr_n;
   logic       ir_ld_n, ir_out_n, a_ld_n, a_out_n, b_ld_n, alu_out_n;
   logic       alu_sub, fl_ld_n, out_ld_n, halted;
   logic [2:0] step;

   control_sequencer dut (
      .i_CLOCK           (clk),
      .i_CLEAR_n         (clr_n),
      .i_RUN             (run),
      .i_OPCODE          (op),
      .i_FLAG_CARRY      (fc),
      .i_FLAG_ZERO       (fz),
      .o_PC_COUNT_ENABLE (pc_cnt),
      .o_PC_JUMP_n       (pc_jmp_n),
      .o_PC_OUTPUT_n     (pc_out_n),
      .o_MAR_LOAD_n      (mar_n),
      .o_RAM_OUTPUT_n    (ram_out_n),
      .o_RAM_WRITE_n     (ram_wr_n),
      .o_IR_LOAD_n       (ir_ld_n),
      .o_IR_OUTPUT_n     (ir_out_n),
      .o_A_LOAD_n        (a_ld_n),
      .o_A_OUTPUT_n      (a_out_n),
      .o_B_LOAD_n        (b_ld_n),
      .o_ALU_OUTPUT_n    (alu_out_n),
      .o_ALU_SUBTRACT    (alu_sub),
      .o_FLAGS_LOAD_n    (fl_ld_n),
      .o_OUT_LOAD_n      (out_ld_n),
      .o_HALTED          (halted),
      .o_STEP            (step)
   );

   always #5 clk = ~clk;

   // Observed outputs in a fixed bench order; IDLE is every control inactive
   localparam logic [15:0] IDLE   = 16'h7FF6;
   localparam logic [15:0] M_PCC  = 16'h8000;
   localparam logic [15:0] M_PCJ  = 16'h4000;
   localparam logic [15:0] M_PCO  = 16'h2000;
   localparam logic [15:0] M_MAR  = 16'h1000;
   localparam logic [15:0] M_RAMO = 16'h0800;
   localparam logic [15:0] M_RAMW = 16'h0400;
   localparam logic [15:0] M_IRL  = 16'h0200;
   localparam logic [15:0] M_IRO  = 16'h0100;
   localparam logic [15:0] M_AL   = 16'h0080;
   localparam logic [15:0] M_AO   = 16'h0040;
   localparam logic [15:0] M_BL   = 16'h0020;
   localparam logic [15:0] M_ALUO = 16'h0010;
   localparam logic [15:0] M_SUB  = 16'h0008;
   localparam logic [15:0] M_FL   = 16'h0004;
   localparam logic [15:0] M_OUTL = 16'h0002;
   localparam logic [15:0] M_HLT  = 16'h0001;

   wire [15:0] obs = {pc_cnt, pc_jmp_n, pc_out_n, mar_n, ram_out_n, ram_wr_n,
                      ir_ld_n, ir_out_n, a_ld_n, a_out_n, b_ld_n, alu_out_n,
                      alu_sub, fl_ld_n, out_ld_n, halted};

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic       run;
      logic [3:0] op;
      logic       c;
      logic       z;
      logic [2:0] step;
      logic [15:0] mask;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic [3:0] o, input logic c,
                               input logic z, input logic [2:0] s, input logic [15:0] m);
      vec_t v;
      v.run = r; v.op = o; v.c = c; v.z = z; v.step = s; v.mask = m;
      vecs.push_back(v);
   endfunction

   function automatic void add_fetch(input logic [3:0] o, input logic c, input logic z);
      add(1'b1, o, c, z, 3'd0, M_PCO | M_MAR);
      add(1'b1, o, c, z, 3'd1, M_RAMO | M_IRL | M_PCC);
   endfunction

   task automatic chk(input string name, input logic [2:0] es, input logic [15:0] mask);
      n_chk++;
      if (step !== es || obs !== (IDLE ^ mask)) begin
         n_err++;
         $display("FAIL %s: got step=%0d ctl=%h, expected step=%0d ctl=%h",
                  name, step, obs, es, IDLE ^ mask);
      end
   endtask

   // Drive one cycle's inputs, check before the edge, then advance past it
   task automatic cyc(input string name, input logic r, input logic [3:0] o,
                      input logic c, input logic z, input logic [2:0] es,
                      input logic [15:0] mask);
      run = r; op = o; fc = c; fz = z;
      #1;
      chk(name, es, mask);
      @(posedge clk);
      #1;
   endtask

   // Bus invariant: never two drivers at once
   always @(negedge clk) begin
      int lows;
      lows = int'(!pc_out_n) + int'(!ram_out_n) + int'(!ir_out_n) +
             int'(!a_out_n) + int'(!alu_out_n);
      n_chk++;
      if (lows > 1) begin
         n_err++;
         $display("FAIL bus_contention: %0d bus drivers low, expected at most 1", lows);
      end
   end

   initial begin
      clr_n = 1'b0; run = 1'b0; op = 4'h0; fc = 1'b0; fz = 1'b0;

      // Table: one row per cycle, starting from T0 right after reset release
      add(1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0);                 // stalled at T0
      add_fetch(4'h0, 0, 0); add(1, 4'h0, 0, 0, 3'd2, 16'h0);    // NOP
      add_fetch(4'h1, 0, 0);                                     // LDA
      add(1, 4'h1, 0, 0, 3'd2, M_IRO | M_MAR);
      add(1, 4'h1, 0, 0, 3'd3, M_RAMO | M_AL);
      add_fetch(4'h2, 0, 0);                                     // ADD
      add(1, 4'h2, 0, 0, 3'd2, M_IRO | M_MAR);
      add(1, 4'h2, 0, 0, 3'd3, M_RAMO | M_BL);
      add(1, 4'h2, 0, 0, 3'd4, M_ALUO | M_AL | M_FL);
      add_fetch(4'h3, 0, 0);                                     // SUB
      add(1, 4'h3, 0, 0, 3'd2, M_IRO | M_MAR);
      add(1, 4'h3, 0, 0, 3'd3, M_RAMO | M_BL);
      add(1, 4'h3, 0, 0, 3'd4, M_ALUO | M_AL | M_FL | M_SUB);
      add_fetch(4'h4, 0, 0);                                     // STA
      add(1, 4'h4, 0, 0, 3'd2, M_IRO | M_MAR);
      add(1, 4'h4, 0, 0, 3'd3, M_AO | M_RAMW);
      add_fetch(4'h5, 0, 0); add(1, 4'h5, 0, 0, 3'd2, M_IRO | M_AL);   // LDI
      add_fetch(4'h6, 0, 0); add(1, 4'h6, 0, 0, 3'd2, M_IRO | M_PCJ);  // JMP
      add_fetch(4'h7, 0, 1); add(1, 4'h7, 0, 1, 3'd2, 16'h0);          // JC C=0
      add_fetch(4'h7, 1, 0); add(1, 4'h7, 1, 0, 3'd2, M_IRO | M_PCJ);  // JC C=1
      add_fetch(4'h8, 1, 0); add(1, 4'h8, 1, 0, 3'd2, 16'h0);          // JZ Z=0
      add_fetch(4'h8, 0, 1); add(1, 4'h8, 0, 1, 3'd2, M_IRO | M_PCJ);  // JZ Z=1
      add_fetch(4'hE, 0, 0); add(1, 4'hE, 0, 0, 3'd2, M_AO | M_OUTL);  // OUT
      add_fetch(4'hB, 0, 0); add(1, 4'hB, 0, 0, 3'd2, 16'h0);          // undefined
      add_fetch(4'h0, 0, 0); add(1, 4'h0, 0, 0, 3'd2, 16'h0);

      // Reset state, with RUN already high to prove reset gates the controls
      @(posedge clk); #1;
      run = 1'b1;
      #1;
      chk("reset_state", 3'd0, 16'h0);
      clr_n = 1'b1;

      foreach (vecs[i]) begin
         cyc($sformatf("vec%0d", i), vecs[i].run, vecs[i].op, vecs[i].c,
             vecs[i].z, vecs[i].step, vecs[i].mask);
      end

      // LDA with asynchronous reset in T3
      cyc("lda_t0", 1, 4'h1, 0, 0, 3'd0, M_PCO | M_MAR);
      cyc("lda_t1", 1, 4'h1, 0, 0, 3'd1, M_RAMO | M_IRL | M_PCC);
      cyc("lda_t2", 1, 4'h1, 0, 0, 3'd2, M_IRO | M_MAR);
      #1;
      chk("lda_t3", 3'd3, M_RAMO | M_AL);
      #1 clr_n = 1'b0;
      #1;
      chk("lda_reset_mid", 3'd0, 16'h0);
      @(posedge clk); #1;
      chk("lda_reset_held", 3'd0, 16'h0);
      clr_n = 1'b1;
      cyc("post_reset_t0", 1, 4'h4, 0, 0, 3'd0, M_PCO | M_MAR);

      // STA with RUN dropped for 4 cycles in T3
      cyc("sta_t1", 1, 4'h4, 0, 0, 3'd1, M_RAMO | M_IRL | M_PCC);
      cyc("sta_t2", 1, 4'h4, 0, 0, 3'd2, M_IRO | M_MAR);
      for (int k = 0; k < 4; k++)
         cyc($sformatf("sta_stall%0d", k), 0, 4'h4, 0, 0, 3'd3, 16'h0);
      cyc("sta_t3_resume", 1, 4'h4, 0, 0, 3'd3, M_AO | M_RAMW);
      cyc("sta_next_t0", 1, 4'hF, 0, 0, 3'd0, M_PCO | M_MAR);

      // HLT: freeze at T2 with controls inactive, then clear
      cyc("hlt_t1", 1, 4'hF, 0, 0, 3'd1, M_RAMO | M_IRL | M_PCC);
      cyc("hlt_t2", 1, 4'hF, 0, 0, 3'd2, 16'h0);
      for (int k = 0; k < 20; k++)
         cyc($sformatf("halted%0d", k), 1, 4'hF, 1, 1, 3'd2, M_HLT);
      clr_n = 1'b0;
      #1;
      chk("hlt_clear", 3'd0, 16'h0);
      @(posedge clk); #1;
      clr_n = 1'b1;
      cyc("after_clear_t0", 1, 4'h0, 0, 0, 3'd0, M_PCO | M_MAR);
      cyc("after_clear_t1", 1, 4'h0, 0, 0, 3'd1, M_RAMO | M_IRL | M_PCC);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
